// File: rtl/karatsuba_seq_ctrl_pkg.sv
// Shared types and width helpers for the sequential Karatsuba multiplier controller.
package karatsuba_seq_ctrl_pkg;

  localparam int KS_N_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_HH  = 3'd1,
    ST_MUL_LL  = 3'd2,
    ST_MUL_MID = 3'd3,
    ST_COMBINE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] PH_HH   = 2'd0;
  localparam logic [1:0] PH_LL   = 2'd1;
  localparam logic [1:0] PH_MID  = 2'd2;
  localparam logic [1:0] PH_NONE = 2'd3;

  function automatic int ks_half_w(input int n);
    return n / 2;
  endfunction

  function automatic int ks_prod_w(input int n);
    return 2 * (n / 2) + 2;
  endfunction

  function automatic int ks_out_w(input int n);
    return 2 * n;
  endfunction

  function automatic logic [1:0] ks_phase_of(input state_e s);
    case (s)
      ST_MUL_HH:  return PH_HH;
      ST_MUL_LL:  return PH_LL;
      ST_MUL_MID: return PH_MID;
      default:    return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/karatsuba_seq_ctrl_seq_mult_unit.sv
// Iterative shift-add unsigned multiplier: bit 0 is folded in at the start edge,
// so the product and a one-cycle done pulse appear W cycles after start.
module seq_mult_unit #(
  parameter int W = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_p
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_done;

  // Load-and-first-step on start, then one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc    <= i_b[0] ? {{W{1'b0}}, i_a} : {(2*W){1'b0}};
        r_mcand  <= {{(W-1){1'b0}}, i_a, 1'b0};
        r_mplier <= i_b >> 1;
        r_cnt    <= CW'(W - 1);
      end else if (r_cnt != '0) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        r_done   <= (r_cnt == CW'(1));
      end
    end
  end

  assign o_done = r_done;
  assign o_p    = r_acc;

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Karatsuba controller: three time-shared (H+1)-bit products k1, k2, k3 combined
// into an N x N unsigned product, with valid/ready handshakes on both sides.
module karatsuba_seq_ctrl
  import karatsuba_seq_ctrl_pkg::*;
#(
  parameter int N = KS_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy,
  output logic [1:0]     phase
);

  localparam int H  = ks_half_w(N);
  localparam int W  = H + 1;
  localparam int KW = ks_prod_w(N);
  localparam int PW = ks_out_w(N);

  state_e         r_state;
  state_e         w_next;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [KW-1:0]  r_k1;
  logic [KW-1:0]  r_k2;
  logic [KW-1:0]  r_k3;
  logic [PW-1:0]  r_p;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;
  logic [1:0]     r_phase;

  logic           w_accept;
  logic           w_start;
  logic [W-1:0]   w_op_a;
  logic [W-1:0]   w_op_b;
  logic           w_done;
  logic [KW-1:0]  w_prod;
  logic [KW-1:0]  w_mid;
  logic [PW-1:0]  w_sum;

  seq_mult_unit #(.W(W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_done  (w_done),
    .o_p     (w_prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; each multiply is launched on the edge that enters its state.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_start  = 1'b0;
    w_op_a   = '0;
    w_op_b   = '0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept = 1'b1;
          w_start  = 1'b1;
          w_op_a   = {1'b0, a[N-1:H]};
          w_op_b   = {1'b0, b[N-1:H]};
          w_next   = ST_MUL_HH;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_MUL_HH: begin
        if (w_done) begin
          w_start = 1'b1;
          w_op_a  = {1'b0, r_a[H-1:0]};
          w_op_b  = {1'b0, r_b[H-1:0]};
          w_next  = ST_MUL_LL;
        end else begin
          w_next = ST_MUL_HH;
        end
      end
      ST_MUL_LL: begin
        if (w_done) begin
          w_start = 1'b1;
          w_op_a  = {1'b0, r_a[N-1:H]} + {1'b0, r_a[H-1:0]};
          w_op_b  = {1'b0, r_b[N-1:H]} + {1'b0, r_b[H-1:0]};
          w_next  = ST_MUL_MID;
        end else begin
          w_next = ST_MUL_LL;
        end
      end
      ST_MUL_MID: begin
        if (w_done) begin
          w_next = ST_COMBINE;
        end else begin
          w_next = ST_MUL_MID;
        end
      end
      ST_COMBINE: w_next = ST_DONE;
      ST_DONE: begin
        if (r_out_valid && out_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // k3 - k1 - k2 equals a_hi*b_lo + a_lo*b_hi, so it fits in KW bits without underflow.
  assign w_mid = r_k3 - r_k1 - r_k2;
  assign w_sum = (PW'(r_k1) << N) + (PW'(w_mid) << H) + PW'(r_k2);

  // Operand capture, partial-product registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_k1        <= '0;
      r_k2        <= '0;
      r_k3        <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_phase     <= PH_NONE;
    end else begin
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
      end
      if (r_state == ST_MUL_HH && w_done) begin
        r_k1 <= w_prod;
      end
      if (r_state == ST_MUL_LL && w_done) begin
        r_k2 <= w_prod;
      end
      if (r_state == ST_MUL_MID && w_done) begin
        r_k3 <= w_prod;
      end
      if (r_state == ST_COMBINE) begin
        r_p <= w_sum;
      end
      r_in_ready  <= (w_next == ST_IDLE);
      r_busy      <= (w_next != ST_IDLE);
      r_out_valid <= (w_next == ST_DONE);
      r_phase     <= ks_phase_of(w_next);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign phase     = r_phase;
  assign p         = r_p;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Self-checking bench: fixed vector table, hand-written corner sequences, and
// random operands compared against plain 64-bit multiplication.
module tb_karatsuba_seq_ctrl;

  localparam int N   = 32;
  localparam int HP1 = N / 2 + 1;
  localparam int LAT = 52;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [1:0]     phase;
  logic [2*N-1:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] vp;
  } vec_t;

  vec_t vecs[8];

  karatsuba_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Each multiply phase lasts H+1 cycles; COMBINE and DONE report "none".
  function automatic logic [1:0] model_phase(input int j);
    return (j / HP1 >= 3) ? 2'd3 : 2'(j / HP1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb);
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic finish_op(input logic [63:0] exp_p, input int hold, input int poke_at);
    int lat;
    bit seq_ok;
    bit st_ok;
    lat = 0;
    seq_ok = 1'b1;
    st_ok = 1'b1;
    out_ready = (hold == 0);
    while (out_valid !== 1'b1 && lat < 2 * LAT) begin
      if (phase !== model_phase(lat) || busy !== 1'b1 || in_ready !== 1'b0) seq_ok = 1'b0;
      if (lat == poke_at) begin
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(LAT));
    check("phase_seq", 64'(seq_ok), 64'd1);
    check("product", p, exp_p);
    if (phase !== 2'd3 || busy !== 1'b1 || in_ready !== 1'b0) st_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_valid !== 1'b1 || p !== exp_p || phase !== 2'd3) st_ok = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    check("done_stable", 64'(st_ok), 64'd1);
    check("handshake_idle", 64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int wait_n;
    bit stray;

    vecs[0] = '{32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0009, 64'd63};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[5] = '{32'hFFFF_0000, 32'h0000_FFFF, 64'h0000_FFFE_0001_0000};
    vecs[6] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[7] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};

    rst = 1'b1;
    tick();
    tick();
    check("rst_state", 64'({in_ready, out_valid, busy, phase}), 64'(5'b10011));
    check("rst_p", p, 64'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].va, vecs[i].vb);
      finish_op(vecs[i].vp, 0, -1);
    end

    // Busy rejection: an in_valid pulse during MUL_LL must be ignored.
    start_op(32'h0, 32'hDEAD_BEEF);
    finish_op(64'h0, 0, 20);
    tick();
    check("no_capture_after_poke", 64'({busy, in_ready}), 64'(2'b01));

    // Backpressure: out_ready low for 10 cycles after out_valid.
    start_op(32'h1234_5678, 32'h8765_4321);
    finish_op(64'(32'h1234_5678) * 64'(32'h8765_4321), 10, -1);

    // Reset during MUL_MID.
    start_op(32'hCAFE_F00D, 32'h0BAD_BEEF);
    repeat (40) tick();
    check("in_mid_phase", 64'(phase), 64'd2);
    rst = 1'b1;
    tick();
    check("rst_mid_state", 64'({in_ready, out_valid, busy, phase}), 64'(5'b10011));
    check("rst_mid_p", p, 64'h0);
    rst = 1'b0;
    stray = 1'b0;
    repeat (60) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    check("no_stray_after_rst", 64'(stray), 64'd0);
    start_op(32'd7, 32'd9);
    finish_op(64'd63, 0, -1);

    // Reset in DONE before the handshake.
    out_ready = 1'b0;
    start_op(32'h0000_1111, 32'h0000_2222);
    wait_n = 0;
    while (out_valid !== 1'b1 && wait_n < 2 * LAT) begin
      tick();
      wait_n++;
    end
    check("done_reached", 64'(out_valid), 64'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done_state", 64'({in_ready, out_valid, busy, phase}), 64'(5'b10011));
    check("rst_done_p", p, 64'h0);
    stray = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    check("no_pulse_after_done_rst", 64'(stray), 64'd0);

    // Random back-to-back operations with random backpressure.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(0, 15) == 0) ra = 32'h0;
      start_op(ra, rb);
      finish_op(64'(ra) * 64'(rb), int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
